// File: rtl/cam_req_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// cam_req_arbiter_pkg: shared helper for index-width sizing.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package cam_req_arbiter_pkg;

  // Index width for an N-entry vector, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cam_req_arbiter_priority_encoder.sv
// ----------------------------------------------------------------------------
// priority_encoder: index of the lowest (HIGH) or highest set request bit.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module priority_encoder #(
  parameter int    WIDTH        = 4,
  parameter string LSB_PRIORITY = "HIGH",
  parameter int    IDX_W        = 2
) (
  input  logic [WIDTH-1:0] req_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  assign valid_o = |req_i;

  generate
    if (LSB_PRIORITY == "HIGH") begin : g_lsb_first
      // Scan downward so the lowest set bit is written last and wins.
      always_comb begin
        idx_o = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
          if (req_i[i]) idx_o = IDX_W'(i);
        end
      end
    end else begin : g_msb_first
      always_comb begin
        idx_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
          if (req_i[i]) idx_o = IDX_W'(i);
        end
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/cam_req_arbiter.sv
// ----------------------------------------------------------------------------
// cam_req_arbiter: round-robin arbiter sharing one CAM request/response port.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cam_req_arbiter
  import cam_req_arbiter_pkg::*;
#(
  parameter int PORTS      = 4,
  parameter int DATA_WIDTH = 48,
  parameter int RSP_WIDTH  = 9,
  parameter int TIMEOUT    = 64,
  localparam int GW        = idx_w(PORTS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PORTS-1:0]            req_valid,
  output logic [PORTS-1:0]            req_ready,
  input  logic [PORTS*DATA_WIDTH-1:0] req_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [DATA_WIDTH-1:0]       m_data,
  input  logic                        s_rsp_valid,
  input  logic [RSP_WIDTH-1:0]        s_rsp_data,
  output logic [PORTS-1:0]            rsp_valid,
  output logic [RSP_WIDTH-1:0]        rsp_data,
  output logic                        rsp_timeout,
  output logic [GW-1:0]               grant_id
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  localparam int             CW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]  C_TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e                  state_q, state_d;
  logic [GW-1:0]           last_grant_q, last_grant_d;
  logic [GW-1:0]           grant_id_q, grant_id_d;
  logic [DATA_WIDTH-1:0]   m_data_q, m_data_d;
  logic [PORTS-1:0]        rsp_valid_q, rsp_valid_d;
  logic [RSP_WIDTH-1:0]    rsp_data_q, rsp_data_d;
  logic                    rsp_timeout_q, rsp_timeout_d;
  logic [CW-1:0]           cnt_q, cnt_d;

  logic [PORTS-1:0]        w_mask;
  logic [PORTS-1:0]        w_masked;
  logic [GW-1:0]           w_m_idx, w_u_idx, w_winner;
  logic                    w_m_any, w_u_any;

  // Requesters strictly above the last grant get first pick.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (GW'(i) > last_grant_q) w_mask[i] = 1'b1;
    end
  end

  assign w_masked = req_valid & w_mask;

  priority_encoder #(
    .WIDTH        (PORTS),
    .LSB_PRIORITY ("HIGH"),
    .IDX_W        (GW)
  ) u_pe_masked (
    .req_i   (w_masked),
    .idx_o   (w_m_idx),
    .valid_o (w_m_any)
  );

  priority_encoder #(
    .WIDTH        (PORTS),
    .LSB_PRIORITY ("HIGH"),
    .IDX_W        (GW)
  ) u_pe_unmasked (
    .req_i   (req_valid),
    .idx_o   (w_u_idx),
    .valid_o (w_u_any)
  );

  assign w_winner = w_m_any ? w_m_idx : w_u_idx;

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    grant_id_d    = grant_id_q;
    m_data_d      = m_data_q;
    rsp_valid_d   = '0;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = 1'b0;
    cnt_d         = cnt_q;
    req_ready     = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (w_u_any) begin
          req_ready    = PORTS'(1) << w_winner;
          for (int i = 0; i < PORTS; i++) begin
            if (w_winner == GW'(i)) m_data_d = req_data[i*DATA_WIDTH +: DATA_WIDTH];
          end
          last_grant_d = w_winner;
          grant_id_d   = w_winner;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (m_ready) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A response in the expiry cycle takes precedence over the timeout.
        if (s_rsp_valid) begin
          rsp_valid_d = PORTS'(1) << grant_id_q;
          rsp_data_d  = s_rsp_data;
          state_d     = ST_IDLE;
        end else if ((TIMEOUT > 0) && (cnt_q == C_TO_LAST)) begin
          rsp_valid_d   = PORTS'(1) << grant_id_q;
          rsp_data_d    = '0;
          rsp_timeout_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= GW'(PORTS - 1);
      grant_id_q    <= '0;
      m_data_q      <= '0;
      rsp_valid_q   <= '0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      grant_id_q    <= grant_id_d;
      m_data_q      <= m_data_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  assign m_valid     = (state_q == ST_ISSUE);
  assign m_data      = m_data_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_timeout = rsp_timeout_q;
  assign grant_id    = grant_id_q;

endmodule

`default_nettype wire

// File: tb/tb_cam_req_arbiter.sv
// ----------------------------------------------------------------------------
// tb_cam_req_arbiter: directed self-checking bench for cam_req_arbiter.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_cam_req_arbiter;

  localparam int PORTS = 4;
  localparam int DW    = 48;
  localparam int RW    = 9;

  logic              clk = 1'b0;
  logic              rst;
  logic [PORTS-1:0]  req_valid;
  logic [PORTS-1:0]  req_ready;
  logic [PORTS*DW-1:0] req_data;
  logic              m_valid;
  logic              m_ready;
  logic [DW-1:0]     m_data;
  logic              s_rsp_valid;
  logic [RW-1:0]     s_rsp_data;
  logic [PORTS-1:0]  rsp_valid;
  logic [RW-1:0]     rsp_data;
  logic              rsp_timeout;
  logic [1:0]        grant_id;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] pdata [PORTS];

  always #5 clk = ~clk;

  cam_req_arbiter #(
    .PORTS      (PORTS),
    .DATA_WIDTH (DW),
    .RSP_WIDTH  (RW),
    .TIMEOUT    (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_data    (req_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .s_rsp_valid (s_rsp_valid),
    .s_rsp_data  (s_rsp_data),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_timeout (rsp_timeout),
    .grant_id    (grant_id)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  int e;

  initial begin
    rst         = 1'b1;
    req_valid   = '0;
    m_ready     = 1'b0;
    s_rsp_valid = 1'b0;
    s_rsp_data  = '0;
    pdata[0] = 48'h111111111111;
    pdata[1] = 48'h222222222222;
    pdata[2] = 48'h333333333333;
    pdata[3] = 48'h444444444444;
    for (int i = 0; i < PORTS; i++) req_data[i*DW +: DW] = pdata[i];
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset_m_valid",     64'(m_valid),     64'd0);
    chk("reset_m_data",      64'(m_data),      64'd0);
    chk("reset_rsp_valid",   64'(rsp_valid),   64'd0);
    chk("reset_rsp_timeout", 64'(rsp_timeout), 64'd0);
    chk("reset_grant_id",    64'(grant_id),    64'd0);
    chk("reset_req_ready",   64'(req_ready),   64'd0);

    // Round-robin with all ports requesting, best-case timing.
    m_ready   = 1'b1;
    req_valid = 4'hF;
    #1;
    for (int t = 0; t < 5; t++) begin
      e = t % 4;
      chk("rr_req_ready", 64'(req_ready), 64'(4'b0001 << e));
      tick();
      chk("rr_m_valid",  64'(m_valid),  64'd1);
      chk("rr_m_data",   64'(m_data),   64'(pdata[e]));
      chk("rr_grant_id", 64'(grant_id), 64'(e));
      tick();
      s_rsp_valid = 1'b1;
      s_rsp_data  = 9'(16 + e);
      tick();
      s_rsp_valid = 1'b0;
      chk("rr_rsp_valid",   64'(rsp_valid),   64'(4'b0001 << e));
      chk("rr_rsp_data",    64'(rsp_data),    64'(16 + e));
      chk("rr_rsp_timeout", 64'(rsp_timeout), 64'd0);
    end
    req_valid = '0;

    // Port 2 alone, CAM stalls for 5 cycles.
    m_ready = 1'b0;
    req_data[2*DW +: DW] = 48'hA1B2C3D4E5F6;
    req_valid = 4'b0100;
    #1;
    chk("stall_req_ready", 64'(req_ready), 64'h4);
    tick();
    req_valid = '0;
    chk("stall_grant_id", 64'(grant_id), 64'd2);
    for (int k = 0; k < 5; k++) begin
      chk("stall_m_valid", 64'(m_valid), 64'd1);
      chk("stall_m_data",  64'(m_data),  64'hA1B2C3D4E5F6);
      tick();
    end
    m_ready = 1'b1;
    tick();
    chk("wait_m_valid", 64'(m_valid), 64'd0);

    // Timeout after 4 WAIT cycles with no response.
    for (int k = 0; k < 4; k++) begin
      chk("to_early_rsp_valid", 64'(rsp_valid), 64'd0);
      if (k < 3) tick();
    end
    tick();
    chk("to_rsp_valid",   64'(rsp_valid),   64'h4);
    chk("to_rsp_timeout", 64'(rsp_timeout), 64'd1);
    chk("to_rsp_data",    64'(rsp_data),    64'd0);
    req_valid = 4'b0001;
    #1;
    chk("to_idle_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = '0;
    chk("to_pulse_valid",   64'(rsp_valid),   64'd0);
    chk("to_pulse_timeout", 64'(rsp_timeout), 64'd0);
    chk("to_grant_id",      64'(grant_id),    64'd0);

    // Reset during WAIT, then a late response.
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    s_rsp_valid = 1'b1;
    s_rsp_data  = 9'h1FF;
    tick();
    s_rsp_valid = 1'b0;
    chk("rst_late_rsp0", 64'(rsp_valid), 64'd0);
    tick();
    chk("rst_late_rsp1", 64'(rsp_valid), 64'd0);
    req_valid = 4'hF;
    #1;
    chk("rst_first_grant", 64'(req_ready), 64'h1);

    // Response and timeout expiry in the same cycle.
    tick();
    req_valid = '0;
    tick();
    tick();
    tick();
    tick();
    s_rsp_valid = 1'b1;
    s_rsp_data  = 9'h0A5;
    tick();
    s_rsp_valid = 1'b0;
    chk("tie_rsp_valid",   64'(rsp_valid),   64'h1);
    chk("tie_rsp_timeout", 64'(rsp_timeout), 64'd0);
    chk("tie_rsp_data",    64'(rsp_data),    64'h0A5);

    // Stray response while IDLE.
    s_rsp_valid = 1'b1;
    tick();
    s_rsp_valid = 1'b0;
    chk("idle_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("idle_m_valid",   64'(m_valid),   64'd0);
    req_valid = 4'b0010;
    #1;
    chk("idle_req_ready", 64'(req_ready), 64'h2);

    // Response in the m handshake cycle is ignored.
    tick();
    req_valid   = '0;
    s_rsp_valid = 1'b1;
    s_rsp_data  = 9'h1EE;
    tick();
    s_rsp_valid = 1'b0;
    chk("hs_rsp_ignored", 64'(rsp_valid), 64'd0);
    s_rsp_valid = 1'b1;
    s_rsp_data  = 9'h033;
    tick();
    s_rsp_valid = 1'b0;
    chk("hs_rsp_valid", 64'(rsp_valid), 64'h2);
    chk("hs_rsp_data",  64'(rsp_data),  64'h033);
    chk("hs_grant_id",  64'(grant_id),  64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
